rf_sequencer: RTL and testbench

RF_SEQUENCER -- requirements
Module: rf_sequencer

---
 rtl/rf_seq_pkg.sv | 26 ++
 rtl/rf_sequencer_if.sv | 49 ++++
 rtl/register_file.sv | 36 +++
 rtl/rf_alu.sv | 50 +++++
 rtl/rf_sequencer.sv | 156 +++++++++++++++
 tb/tb_rf_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/rf_seq_pkg.sv
// Shared definitions for the register-file sequencer: opcode and FSM state
// encodings plus the default address/data widths.
package rf_seq_pkg;

  localparam int unsigned N_DEF = 4;
  localparam int unsigned W_DEF = 16;

  typedef enum logic [2:0] {
    OP_NOP = 3'd0,
    OP_ADD = 3'd1,
    OP_SUB = 3'd2,
    OP_AND = 3'd3,
    OP_OR  = 3'd4,
    OP_XOR = 3'd5,
    OP_MOV = 3'd6,
    OP_LDI = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_e;

endpackage

// File: rtl/rf_sequencer_if.sv
// Command and register-file bus of the sequencer.
//   master : command issuer (drives cmd_*, observes ready/done/result/flags)
//   slave  : the sequencer itself
//   rf     : register file (takes write/address lines, returns read data)
interface rf_sequencer_if #(
  parameter int unsigned N = rf_seq_pkg::N_DEF,
  parameter int unsigned W = rf_seq_pkg::W_DEF
) ();
  import rf_seq_pkg::*;

  logic         cmd_valid;
  logic         cmd_ready;
  op_e          cmd_op;
  logic [N-1:0] cmd_rd;
  logic [N-1:0] cmd_rs1;
  logic [N-1:0] cmd_rs2;
  logic [W-1:0] cmd_imm;

  logic         done;
  logic [W-1:0] result;
  logic         flag_zero;
  logic         flag_carry;

  logic         rf_we;
  logic [N-1:0] rf_addr_rd;
  logic [N-1:0] rf_addr_rs1;
  logic [N-1:0] rf_addr_rs2;
  logic [W-1:0] rf_data_in;
  logic [W-1:0] rf_rs1;
  logic [W-1:0] rf_rs2;

  modport master (
    output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
    input  cmd_ready, done, result, flag_zero, flag_carry
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
    output cmd_ready, done, result, flag_zero, flag_carry,
    output rf_we, rf_addr_rd, rf_addr_rs1, rf_addr_rs2, rf_data_in,
    input  rf_rs1, rf_rs2
  );

  modport rf (
    input  rf_we, rf_addr_rd, rf_addr_rs1, rf_addr_rs2, rf_data_in,
    output rf_rs1, rf_rs2
  );

endinterface

// File: rtl/register_file.sv
// 2**N x W register file; r0 reads as zero because writes to it are dropped.
//   clk, rst      : clock, synchronous active-high clear
//   bus (rf)      : write port plus two combinational read ports
//   i_dbg_addr    : spare read address
//   o_dbg_data_c  : spare combinational read data
module register_file
  import rf_seq_pkg::*;
#(
  parameter int unsigned N = N_DEF,
  parameter int unsigned W = W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  rf_sequencer_if.rf   bus,
  input  logic [N-1:0] i_dbg_addr,
  output logic [W-1:0] o_dbg_data_c
);

  localparam int unsigned DEPTH = 1 << N;

  logic [W-1:0] r_mem [DEPTH];

  // Write port; address 0 is read-only zero
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (bus.rf_we && (bus.rf_addr_rd != '0)) begin
      r_mem[bus.rf_addr_rd] <= bus.rf_data_in;
    end
  end

  assign bus.rf_rs1   = r_mem[bus.rf_addr_rs1];
  assign bus.rf_rs2   = r_mem[bus.rf_addr_rs2];
  assign o_dbg_data_c = r_mem[i_dbg_addr];

endmodule

// File: rtl/rf_alu.sv
// Combinational ALU for the sequencer.
//   i_op      : opcode
//   i_a, i_b  : source operands
//   i_imm     : immediate (LDI only)
//   o_y_c     : result, modulo 2**W
//   o_carry_c : ADD carry-out / SUB borrow, 0 otherwise
//   o_zero_c  : result == 0
module rf_alu
  import rf_seq_pkg::*;
#(
  parameter int unsigned W = W_DEF
) (
  input  op_e          i_op,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [W-1:0] i_imm,
  output logic [W-1:0] o_y_c,
  output logic         o_carry_c,
  output logic         o_zero_c
);

  logic [W:0] w_sum;

  always_comb begin
    w_sum     = '0;
    o_y_c     = '0;
    o_carry_c = 1'b0;
    case (i_op)
      OP_ADD: begin
        w_sum     = {1'b0, i_a} + {1'b0, i_b};
        o_y_c     = w_sum[W-1:0];
        o_carry_c = w_sum[W];
      end
      OP_SUB: begin
        // Top bit of the widened difference is set exactly when a < b
        w_sum     = {1'b0, i_a} - {1'b0, i_b};
        o_y_c     = w_sum[W-1:0];
        o_carry_c = w_sum[W];
      end
      OP_AND:  o_y_c = i_a & i_b;
      OP_OR:   o_y_c = i_a | i_b;
      OP_XOR:  o_y_c = i_a ^ i_b;
      OP_MOV:  o_y_c = i_a;
      OP_LDI:  o_y_c = i_imm;
      default: o_y_c = '0;
    endcase
    o_zero_c = (o_y_c == '0);
  end

endmodule

// File: rtl/rf_sequencer.sv
// Four-phase command sequencer: IDLE -> READ -> EXEC -> WB, one command per
// four cycles. Reads two registers, runs the ALU, writes the destination.
//   clk, rst  : clock, synchronous active-high reset
//   bus (slave): command handshake, retire status, register-file port
module rf_sequencer
  import rf_seq_pkg::*;
#(
  parameter int unsigned N = N_DEF,
  parameter int unsigned W = W_DEF
) (
  input  logic          clk,
  input  logic          rst,
  rf_sequencer_if.slave bus
);

  state_e       r_state,    w_state;
  logic         r_ready,    w_ready;
  logic         r_done,     w_done;
  logic         r_we,       w_we;
  op_e          r_op,       w_op;
  logic [N-1:0] r_rd,       w_rd;
  logic [W-1:0] r_imm,      w_imm;
  logic [W-1:0] r_a,        w_a;
  logic [W-1:0] r_b,        w_b;
  logic [N-1:0] r_addr_rd,  w_addr_rd;
  logic [N-1:0] r_addr_rs1, w_addr_rs1;
  logic [N-1:0] r_addr_rs2, w_addr_rs2;
  logic [W-1:0] r_data_in,  w_data_in;
  logic [W-1:0] r_result,   w_result;
  logic         r_zero,     w_zero;
  logic         r_carry,    w_carry;

  logic [W-1:0] w_alu_y;
  logic         w_alu_carry;
  logic         w_alu_zero;

  rf_alu #(.W(W)) u_alu (
    .i_op      (r_op),
    .i_a       (r_a),
    .i_b       (r_b),
    .i_imm     (r_imm),
    .o_y_c     (w_alu_y),
    .o_carry_c (w_alu_carry),
    .o_zero_c  (w_alu_zero)
  );

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_ready    <= 1'b1;
      r_done     <= 1'b0;
      r_we       <= 1'b0;
      r_op       <= OP_NOP;
      r_rd       <= '0;
      r_imm      <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_addr_rd  <= '0;
      r_addr_rs1 <= '0;
      r_addr_rs2 <= '0;
      r_data_in  <= '0;
      r_result   <= '0;
      r_zero     <= 1'b0;
      r_carry    <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_ready    <= w_ready;
      r_done     <= w_done;
      r_we       <= w_we;
      r_op       <= w_op;
      r_rd       <= w_rd;
      r_imm      <= w_imm;
      r_a        <= w_a;
      r_b        <= w_b;
      r_addr_rd  <= w_addr_rd;
      r_addr_rs1 <= w_addr_rs1;
      r_addr_rs2 <= w_addr_rs2;
      r_data_in  <= w_data_in;
      r_result   <= w_result;
      r_zero     <= w_zero;
      r_carry    <= w_carry;
    end
  end

  // Next state; outputs are computed one cycle ahead so they are registered
  // on entry to the state that presents them.
  always_comb begin
    w_state    = r_state;
    w_ready    = 1'b0;
    w_done     = 1'b0;
    w_we       = 1'b0;
    w_op       = r_op;
    w_rd       = r_rd;
    w_imm      = r_imm;
    w_a        = r_a;
    w_b        = r_b;
    w_addr_rd  = r_addr_rd;
    w_addr_rs1 = r_addr_rs1;
    w_addr_rs2 = r_addr_rs2;
    w_data_in  = r_data_in;
    w_result   = r_result;
    w_zero     = r_zero;
    w_carry    = r_carry;

    case (r_state)
      ST_IDLE: begin
        w_ready = 1'b1;
        if (bus.cmd_valid && r_ready) begin
          w_state    = ST_READ;
          w_ready    = 1'b0;
          w_op       = bus.cmd_op;
          w_rd       = bus.cmd_rd;
          w_imm      = bus.cmd_imm;
          w_addr_rs1 = bus.cmd_rs1;
          w_addr_rs2 = bus.cmd_rs2;
        end
      end
      ST_READ: begin
        w_state = ST_EXEC;
        w_a     = bus.rf_rs1;
        w_b     = bus.rf_rs2;
      end
      ST_EXEC: begin
        w_state   = ST_WB;
        w_done    = 1'b1;
        w_addr_rd = r_rd;
        w_data_in = w_alu_y;
        // NOP retires without writing or disturbing result/flags
        if (r_op != OP_NOP) begin
          w_we     = 1'b1;
          w_result = w_alu_y;
          w_zero   = w_alu_zero;
          w_carry  = w_alu_carry;
        end
      end
      ST_WB: begin
        w_state = ST_IDLE;
        w_ready = 1'b1;
      end
      default: w_state = ST_IDLE;
    endcase
  end

  assign bus.cmd_ready   = r_ready;
  assign bus.done        = r_done;
  assign bus.result      = r_result;
  assign bus.flag_zero   = r_zero;
  assign bus.flag_carry  = r_carry;
  assign bus.rf_we       = r_we;
  assign bus.rf_addr_rd  = r_addr_rd;
  assign bus.rf_addr_rs1 = r_addr_rs1;
  assign bus.rf_addr_rs2 = r_addr_rs2;
  assign bus.rf_data_in  = r_data_in;

endmodule

// File: tb/tb_rf_sequencer.sv
// Bench for rf_sequencer + register_file: transaction-level reference model,
// per-cycle output comparison, directed scenarios and random commands.
module tb_rf_sequencer;
  import rf_seq_pkg::*;

  localparam int unsigned N    = 4;
  localparam int unsigned W    = 16;
  localparam int unsigned NREG = 16;

  logic         clk = 1'b0;
  logic         seq_rst;
  logic         rf_rst;
  logic [N-1:0] dbg_addr;
  logic [W-1:0] dbg_data;

  rf_sequencer_if #(.N(N), .W(W)) bus ();

  rf_sequencer #(.N(N), .W(W)) dut (
    .clk (clk),
    .rst (seq_rst),
    .bus (bus)
  );

  register_file #(.N(N), .W(W)) u_rf (
    .clk          (clk),
    .rst          (rf_rst),
    .bus          (bus),
    .i_dbg_addr   (dbg_addr),
    .o_dbg_data_c (dbg_data)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  logic [W-1:0] m_regs [NREG];
  int           cyc       = 0;
  bit           armed     = 1'b0;
  bit           m_busy    = 1'b0;
  int           m_hs_edge = 0;
  int           hs_count  = 0;
  op_e          p_op;
  logic [N-1:0] p_rd, p_rs1, p_rs2;
  logic [W-1:0] p_y;
  logic         p_c, p_z;
  logic [W-1:0] m_result = '0;
  logic         m_zero   = 1'b0;
  logic         m_carry  = 1'b0;
  bit           in_stream = 1'b0;
  int           last_rdy  = -1;

  function automatic void ref_alu(input op_e op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [W-1:0] imm, output logic [W-1:0] y, output logic c);
    int unsigned ua, ub;
    ua = 32'(a);
    ub = 32'(b);
    c  = 1'b0;
    case (op)
      OP_ADD: begin y = W'(ua + ub); c = (ua + ub) >= (32'd1 << W); end
      OP_SUB: begin y = W'(ua - ub); c = (ua < ub); end
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_XOR: y = a ^ b;
      OP_MOV: y = a;
      OP_LDI: y = imm;
      default: y = '0;
    endcase
  endfunction

  // Model advances at each rising edge: accept, retire, write back, reset
  always @(posedge clk) begin
    cyc++;
    if (seq_rst) begin
      armed    = 1'b1;
      m_busy   = 1'b0;
      m_result = '0;
      m_zero   = 1'b0;
      m_carry  = 1'b0;
    end else if (m_busy) begin
      if (cyc - m_hs_edge == 2 && p_op != OP_NOP) begin
        m_result = p_y;
        m_zero   = p_z;
        m_carry  = p_c;
      end
      if (cyc - m_hs_edge == 3) begin
        if (p_op != OP_NOP && p_rd != '0) m_regs[p_rd] = p_y;
        m_busy = 1'b0;
      end
    end else if (bus.cmd_valid) begin
      p_op  = bus.cmd_op;
      p_rd  = bus.cmd_rd;
      p_rs1 = bus.cmd_rs1;
      p_rs2 = bus.cmd_rs2;
      ref_alu(p_op, m_regs[p_rs1], m_regs[p_rs2], bus.cmd_imm, p_y, p_c);
      p_z       = (p_y == '0);
      m_busy    = 1'b1;
      m_hs_edge = cyc;
      hs_count++;
    end
  end

  // Per-cycle comparison on the falling edge
  always @(negedge clk) begin
    int ph;
    bit wb;
    if (armed) begin
      ph = cyc - m_hs_edge;
      wb = m_busy && (ph == 2);
      check("cmd_ready",  32'(bus.cmd_ready),  32'(!m_busy));
      check("done",       32'(bus.done),       32'(wb));
      check("rf_we",      32'(bus.rf_we),      32'(wb && p_op != OP_NOP));
      check("result",     32'(bus.result),     32'(m_result));
      check("flag_zero",  32'(bus.flag_zero),  32'(m_zero));
      check("flag_carry", 32'(bus.flag_carry), 32'(m_carry));
      if (m_busy && ph == 0) begin
        check("rf_addr_rs1", 32'(bus.rf_addr_rs1), 32'(p_rs1));
        check("rf_addr_rs2", 32'(bus.rf_addr_rs2), 32'(p_rs2));
      end
      if (wb && p_op != OP_NOP) begin
        check("rf_addr_rd", 32'(bus.rf_addr_rd), 32'(p_rd));
        check("rf_data_in", 32'(bus.rf_data_in), 32'(p_y));
      end
      if (in_stream && bus.cmd_ready) begin
        if (last_rdy >= 0) check("ready_spacing", 32'(cyc - last_rdy), 32'd4);
        last_rdy = cyc;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input op_e op, input int rd, input int rs1, input int rs2, input logic [W-1:0] imm);
    bus.cmd_op  = op;
    bus.cmd_rd  = N'(rd);
    bus.cmd_rs1 = N'(rs1);
    bus.cmd_rs2 = N'(rs2);
    bus.cmd_imm = imm;
  endtask

  // Wait (bounded) for the model to register a handshake after count h0
  task automatic wait_hs(input int h0, output bit ok);
    int k;
    k = 0;
    while (hs_count == h0 && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    ok = (hs_count != h0);
    if (!ok) check("handshake_timeout", 32'd0, 32'd1);
  endtask

  // Issue one command, check done arrives on the 3rd cycle after acceptance
  task automatic send(input op_e op, input int rd, input int rs1, input int rs2, input logic [W-1:0] imm);
    int h0, lat;
    bit ok;
    @(negedge clk);
    drive(op, rd, rs1, rs2, imm);
    bus.cmd_valid = 1'b1;
    h0 = hs_count;
    wait_hs(h0, ok);
    bus.cmd_valid = 1'b0;
    if (ok) begin
      lat = 0;
      do begin
        @(negedge clk);
        lat++;
      end while (!bus.done && lat < 10);
      check("done_latency", 32'(lat), 32'd3);
      @(posedge clk); #1;
    end
  endtask

  task automatic rd_reg(input string name, input int a, input logic [W-1:0] exp);
    dbg_addr = N'(a);
    #1;
    check(name, 32'(dbg_data), 32'(exp));
  endtask

  task automatic chk_outs(input string name, input logic [W-1:0] res, input logic z, input logic c);
    check({name, "_result"}, 32'(bus.result), 32'(res));
    check({name, "_zero"},   32'(bus.flag_zero), 32'(z));
    check({name, "_carry"},  32'(bus.flag_carry), 32'(c));
  endtask

  task automatic chk_reset_state(input string name);
    check({name, "_ready"},   32'(bus.cmd_ready), 32'd1);
    check({name, "_done"},    32'(bus.done), 32'd0);
    check({name, "_we"},      32'(bus.rf_we), 32'd0);
    check({name, "_result"},  32'(bus.result), 32'd0);
    check({name, "_flags"},   32'({bus.flag_zero, bus.flag_carry}), 32'd0);
    check({name, "_addr"},    32'({bus.rf_addr_rd, bus.rf_addr_rs1, bus.rf_addr_rs2}), 32'd0);
    check({name, "_data_in"}, 32'(bus.rf_data_in), 32'd0);
  endtask

  op_e          s_op  [3];
  int           s_rd  [3];
  int           s_a   [3];
  int           s_b   [3];
  logic [W-1:0] s_imm [3];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    bit ok;
    int h0;
    for (int i = 0; i < int'(NREG); i++) m_regs[i] = '0;
    seq_rst       = 1'b1;
    rf_rst        = 1'b1;
    bus.cmd_valid = 1'b0;
    drive(OP_NOP, 0, 0, 0, '0);
    dbg_addr = '0;
    repeat (3) @(negedge clk);
    chk_reset_state("reset");
    seq_rst = 1'b0;
    rf_rst  = 1'b0;

    // Basic add chain
    send(OP_LDI, 1, 0, 0, 16'h1234);
    send(OP_LDI, 2, 0, 0, 16'h5678);
    send(OP_ADD, 3, 1, 2, 16'h0000);
    chk_outs("add", 16'h68AC, 1'b0, 1'b0);
    rd_reg("r3", 3, 16'h68AC);

    // Carry / borrow / zero
    send(OP_LDI, 4, 0, 0, 16'hFFFF);
    send(OP_LDI, 5, 0, 0, 16'h0001);
    send(OP_ADD, 6, 4, 5, 16'h0000);
    chk_outs("add_wrap", 16'h0000, 1'b1, 1'b1);
    rd_reg("r6", 6, 16'h0000);
    send(OP_SUB, 7, 5, 4, 16'h0000);
    chk_outs("sub_borrow", 16'h0002, 1'b0, 1'b1);
    rd_reg("r7", 7, 16'h0002);

    // Writes to r0 report the value but are dropped; NOP leaves state alone
    send(OP_LDI, 0, 0, 0, 16'hABCD);
    chk_outs("ldi_r0", 16'hABCD, 1'b0, 1'b0);
    rd_reg("r0", 0, 16'h0000);
    send(OP_NOP, 1, 2, 3, 16'h5555);
    chk_outs("nop", 16'hABCD, 1'b0, 1'b0);
    rd_reg("r1_after_nop", 1, 16'h1234);
    send(OP_LDI, 8, 0, 0, 16'h7777);
    send(OP_MOV, 8, 0, 0, 16'h0000);
    chk_outs("mov_r0", 16'h0000, 1'b1, 1'b0);
    rd_reg("r8", 8, 16'h0000);

    // Continuous cmd_valid, dependent commands
    s_op[0] = OP_LDI; s_rd[0] = 11; s_a[0] = 0;  s_b[0] = 0;  s_imm[0] = 16'h0F0F;
    s_op[1] = OP_ADD; s_rd[1] = 12; s_a[1] = 11; s_b[1] = 11; s_imm[1] = 16'h0000;
    s_op[2] = OP_XOR; s_rd[2] = 9;  s_a[2] = 3;  s_b[2] = 3;  s_imm[2] = 16'h0000;
    @(negedge clk);
    last_rdy  = -1;
    in_stream = 1'b1;
    drive(s_op[0], s_rd[0], s_a[0], s_b[0], s_imm[0]);
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      h0 = hs_count;
      wait_hs(h0, ok);
      if (i < 2) drive(s_op[i+1], s_rd[i+1], s_a[i+1], s_b[i+1], s_imm[i+1]);
    end
    in_stream     = 1'b0;
    bus.cmd_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk_outs("xor_self", 16'h0000, 1'b1, 1'b0);
    rd_reg("r11", 11, 16'h0F0F);
    rd_reg("r12", 12, 16'h1E1E);
    rd_reg("r9", 9, 16'h0000);

    // Reset pulse while LDI r10 is in EXEC
    @(negedge clk);
    drive(OP_LDI, 10, 0, 0, 16'hBEEF);
    bus.cmd_valid = 1'b1;
    h0 = hs_count;
    wait_hs(h0, ok);
    bus.cmd_valid = 1'b0;
    @(negedge clk);            // READ
    @(negedge clk);            // EXEC
    seq_rst = 1'b1;
    @(negedge clk);
    seq_rst = 1'b0;
    chk_reset_state("midreset");
    repeat (6) @(negedge clk);
    rd_reg("r10_abandoned", 10, 16'h0000);
    send(OP_LDI, 10, 0, 0, 16'h1111);
    chk_outs("after_reset", 16'h1111, 1'b0, 1'b0);
    rd_reg("r10", 10, 16'h1111);

    // Random commands
    for (int n = 0; n < 150; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(op_e'(3'($urandom_range(0, 7))), int'($urandom_range(0, 15)),
           int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), W'($urandom));
    end

    for (int i = 0; i < int'(NREG); i++) rd_reg("reg_dump", i, m_regs[i]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
